// File: rtl/port_uart_tx.sv
// CPU output-port peripheral: bytes written to the port are queued in a small
// FIFO and sent as 8N1 frames on tx, with a pollable status byte.
module port_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       clr_ovf,
    output logic       tx,
    output logic [7:0] status
);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  COUNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         sh_q, sh_d;
    logic               tx_q, tx_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [7:0]         mem_q [FIFO_DEPTH];

    logic full;
    logic empty;
    logic baud_done;
    logic push;
    logic pop;

    // Full is judged on the pre-edge count, so a same-edge pop never frees a slot.
    assign full      = (count_q == COUNT_FULL);
    assign empty     = (count_q == '0);
    assign baud_done = (baud_q == BAUD_LAST);
    assign push      = wr_en && !full;

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        sh_d      = sh_q;
        tx_d      = tx_q;
        ovf_d     = ovf_q;
        count_d   = count_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        pop       = 1'b0;

        // tx_d always carries the level of the state being entered, keeping tx registered.
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = START;
                    baud_d  = '0;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (baud_done) begin
                    state_d   = DATA;
                    baud_d    = '0;
                    bit_idx_d = 3'd0;
                    tx_d      = sh_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        sh_d      = sh_q >> 1;
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = sh_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        if (pop) begin
            sh_d     = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (wr_en && full) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= 3'd0;
            sh_q      <= 8'h00;
            tx_q      <= 1'b1;
            ovf_q     <= 1'b0;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            sh_q      <= sh_d;
            tx_q      <= tx_d;
            ovf_q     <= ovf_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign tx     = tx_q;
    assign status = {4'b0000, ovf_q, (state_q != IDLE), empty, full};

endmodule

// File: tb/tb_port_uart_tx.sv
// Scoreboard bench for port_uart_tx: a frame-timing reference model predicts
// tx/status per cycle and the expected frames; a UART receiver checks them.
module tb_port_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       clr_ovf;
    logic       tx;
    logic [7:0] status;

    port_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .clr_ovf (clr_ovf),
        .tx      (tx),
        .status  (status)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         start;
    } frame_t;

    frame_t     frames[$];
    frame_t     exp_q[$];
    frame_t     new_frame;
    int         cyc = 0;
    int         last_start = -1000;
    int         pending;
    int         post_cnt;
    int         slot;
    int         compared = 0;
    int         mismatched = 0;
    bit         ovf_m = 1'b0;
    bit         active;
    bit         checking = 1'b0;
    bit         rx_abort = 1'b0;
    bit         rx_busy = 1'b0;
    bit         exp_tx_m = 1'b1;
    logic [7:0] exp_status = 8'h02;
    int         rx_start;
    int         rx_off;
    logic [9:0] rx_bits;

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s at edge %0d: got %0h, expected %0h", name, cyc, got, exp);
        end
    endtask

    // Reference model: each accepted byte starts its frame one edge after the
    // write, or right when the previous frame ends, whichever is later.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (reset) begin
            frames.delete();
            exp_q.delete();
            last_start = -1000;
            ovf_m      = 1'b0;
            checking   = 1'b1;
            rx_abort   = 1'b1;
        end else begin
            pending = 0;
            foreach (frames[i]) if (frames[i].start >= cyc) pending++;
            if (wr_en && pending >= DEPTH) begin
                ovf_m = 1'b1;
            end else begin
                if (clr_ovf) ovf_m = 1'b0;
                if (wr_en) begin
                    new_frame.data  = wr_data;
                    new_frame.start = (cyc + 1 > last_start + FRAME) ? cyc + 1 : last_start + FRAME;
                    last_start = new_frame.start;
                    frames.push_back(new_frame);
                    exp_q.push_back(new_frame);
                end
            end
        end
        while (frames.size() > 0 && frames[0].start + FRAME <= cyc) frames.delete(0);
        post_cnt = 0;
        active   = 1'b0;
        exp_tx_m = 1'b1;
        foreach (frames[i]) begin
            if (frames[i].start > cyc) begin
                post_cnt++;
            end else if (cyc < frames[i].start + FRAME) begin
                active = 1'b1;
                slot   = (cyc - frames[i].start) / CPB;
                if (slot == 0)      exp_tx_m = 1'b0;
                else if (slot <= 8) exp_tx_m = frames[i].data[slot-1];
                else                exp_tx_m = 1'b1;
            end
        end
        exp_status = {4'b0000, ovf_m, active, (post_cnt == 0), (post_cnt == DEPTH)};
    end

    task automatic score_frame();
        frame_t e;
        if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL frame_unexpected at edge %0d: got byte %0h, expected no frame", cyc, rx_bits[8:1]);
        end else begin
            e = exp_q.pop_front();
            check_output("frame_data", rx_bits[8:1], e.data);
            check_output("frame_start", rx_start, e.start);
            check_output("frame_stop", rx_bits[9], 1);
        end
    endtask

    // Monitor: per-cycle tx/status against the model, plus a mid-bit UART receiver.
    always @(negedge clk) begin
        if (checking) begin
            if (rx_abort) begin
                rx_busy  = 1'b0;
                rx_abort = 1'b0;
            end
            check_output("tx", tx, exp_tx_m);
            check_output("status", status, exp_status);
            if (!rx_busy && tx === 1'b0) begin
                rx_busy  = 1'b1;
                rx_start = cyc;
            end
            if (rx_busy) begin
                rx_off = cyc - rx_start;
                if (rx_off % CPB == CPB / 2) begin
                    rx_bits[rx_off / CPB] = tx;
                    if (rx_off / CPB == 9) begin
                        rx_busy = 1'b0;
                        score_frame();
                    end
                end
            end
        end
    end

    task automatic apply_stimulus(input logic we, input logic [7:0] d, input logic clr, input logic rst);
        @(negedge clk);
        wr_en   = we;
        wr_data = d;
        clr_ovf = clr;
        reset   = rst;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Next apply_stimulus after this returns is sampled at edge t.
    task automatic idle_until(input int t);
        while (cyc < t - 2) apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || cyc < last_start + FRAME) && n < bound) begin
            apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
            n++;
        end
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drain_timeout at edge %0d: got %0d frames outstanding, expected 0", cyc, exp_q.size());
        end
    endtask

    initial begin
        int e0;
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        clr_ovf = 1'b0;
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
        check_output("reset_status", status, 8'h02);
        check_output("reset_tx", tx, 1);
        idle_cycles(20);

        $display("[TB] single byte A5");
        apply_stimulus(1'b1, 8'hA5, 1'b0, 1'b0);
        e0 = cyc + 1;
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
        check_output("a5_status_queued", status, 8'h00);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
        check_output("a5_status_sending", status, 8'h06);
        check_output("a5_start_bit", tx, 0);
        drain(100);
        idle_cycles(5);

        $display("[TB] burst 01..06 with overflow");
        for (int i = 1; i <= 6; i++) apply_stimulus(1'b1, 8'(i), 1'b0, 1'b0);
        apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
        check_output("burst_status_ovf", status, 8'h0D);
        apply_stimulus(1'b1, 8'h07, 1'b1, 1'b0);
        check_output("clr_ovf_status", status, 8'h05);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
        check_output("set_wins_status", status, 8'h0D);
        drain(300);
        apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
        idle_cycles(5);

        $display("[TB] reset during data bit 3");
        apply_stimulus(1'b1, 8'h96, 1'b0, 1'b0);
        e0 = cyc + 1;
        apply_stimulus(1'b1, 8'h5A, 1'b0, 1'b0);
        apply_stimulus(1'b1, 8'hC3, 1'b0, 1'b0);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
        idle_until(e0 + 18);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
        check_output("midreset_status", status, 8'h02);
        check_output("midreset_tx", tx, 1);
        idle_cycles(60);
        apply_stimulus(1'b1, 8'h3C, 1'b0, 1'b0);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
        drain(100);

        $display("[TB] write on the same edge as a back-to-back pop");
        apply_stimulus(1'b1, 8'h11, 1'b0, 1'b0);
        e0 = cyc + 1;
        apply_stimulus(1'b1, 8'h22, 1'b0, 1'b0);
        apply_stimulus(1'b1, 8'h33, 1'b0, 1'b0);
        apply_stimulus(1'b1, 8'h44, 1'b0, 1'b0);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
        idle_until(e0 + 41);
        apply_stimulus(1'b1, 8'hE7, 1'b0, 1'b0);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
        check_output("same_edge_status", status, 8'h04);
        drain(300);

        $display("[TB] randomized traffic");
        repeat (600) begin
            apply_stimulus(($urandom_range(0, 99) < 12), 8'($urandom), ($urandom_range(0, 19) == 0),
                           ($urandom_range(0, 299) == 0));
        end
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
        drain(400);
        idle_cycles(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog at edge %0d: got no completion, expected finish", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/port_uart_tx.md
Name: port_uart_tx

Overview:
- Output-port peripheral that drains bytes the CPU writes to an output port.
- Bytes are buffered in a small FIFO and sent as 8N1 asynchronous serial frames on a single `tx` line.
- It is the consuming end of the CPU port-write path.
- A status byte is returned on a CPU input port so firmware can poll for space or idle before writing.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit (≥2).
- FIFO_DEPTH, 4, byte entries in the transmit FIFO (power of two, ≥2).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  one-cycle port-write strobe from the CPU (we_port decoded for this port).
- wr_data  input  8  byte written by the CPU (the out_pN value).
- clr_ovf  input  1  one-cycle strobe; clears the sticky overflow flag.
- tx  output  1  serial line; idles high.
- status  output  8  {4'b0, overflow, tx_active, fifo_empty, fifo_full}; wired to a CPU input port.

Behaviour:
- Reset (synchronous, active-high, overrides everything):
  - FIFO count 0; read and write pointers 0.
  - FSM IDLE; baud counter 0; bit index 0.
  - tx=1; overflow=0.
  - Hence status=8'h02.
  - Mid-frame reset: tx returns high at the next edge; the partial frame and all queued bytes are discarded.
- FIFO writes:
  - wr_en=1 and not full: wr_data is stored at the write pointer and count increments on the edge.
  - wr_en=1 while full: the byte is dropped and overflow is set.
  - The full test uses the pre-edge count. A pop on the same edge does not make room.
  - Write and pop on the same edge when not full: both take effect; count is unchanged.
- Overflow flag:
  - Sticky; cleared only by clr_ovf or reset.
  - clr_ovf and an overflowing write on the same edge: overflow ends at 1 (set wins).
- Status bits: fifo_full, fifo_empty and tx_active (FSM ≠ IDLE) reflect registered state. They are outputs of registers, not combinational from inputs.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE:
    - tx=1.
    - If FIFO non-empty: pop the head into shift register sh, go to START, clear the baud counter.
  - START:
    - tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA:
    - tx=sh[0] for CLKS_PER_BIT cycles, then shift sh right and increment bit index.
    - After bit 7 is held, go to STOP.
    - Order: LSB first.
  - STOP:
    - tx=1 for CLKS_PER_BIT cycles.
    - At the end: if FIFO non-empty, pop and go directly to START (back-to-back frames, no idle gap); else go to IDLE.
- tx is registered; no glitches.
- Frame length is exactly 10·CLKS_PER_BIT cycles.
- Latency:
  - Byte written at edge N into an empty FIFO while IDLE: popped at edge N+1; tx low from edge N+1.
  - The first data bit appears at edge N+1+CLKS_PER_BIT.
- Pointer arithmetic: pointers wrap modulo FIFO_DEPTH; count has log2(FIFO_DEPTH)+1 bits.
- No flow control on tx; CPU firmware must honour fifo_full.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset, then idle 20 cycles → tx=1 and status=8'h02 on every cycle.
- Write 8'hA5 at edge 0 →
  - tx low over edges 1–4.
  - Data bits 1,0,1,0,0,1,0,1 in 4-cycle slots from edge 5.
  - tx high from edge 37; status bit2 falls at edge 41.
  - 40-cycle frame in total.
- Write 8'h01..8'h06 on six consecutive edges (0–5) →
  - Bytes 01–05 are accepted.
  - 06 is dropped at edge 5 with fifo_full=1; overflow=1 (status=8'h0D).
  - Frames 01–05 are sent back-to-back with no idle gap, 200 cycles total.
- Continuing from the previous scenario: pulse clr_ovf → status bit3 clears next edge. Then pulse clr_ovf together with a write while full → overflow stays 1.
- Reset asserted mid-DATA bit 3 with 2 bytes queued →
  - At the next edge: tx=1, status=8'h02.
  - No further frames are sent.
  - A fresh write afterward transmits correctly.
- Write while the FIFO holds 3 bytes, on the same edge as a STOP→START pop → count stays 3 and all bytes are transmitted in write order.
